// File: rtl/byte_load_unit.sv
// byte_load_unit: memory-read side of the byte datapath.
// Fetches a 16-bit word over a req/ack handshake and returns either the whole
// word or one little-endian byte lane, zero- or sign-extended to 16 bits.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        one-cycle load request, sampled only when idle
//   addr         byte address of the load
//   wb           0 = word access, 1 = byte access
//   sx           byte access: 0 = zero-extend, 1 = sign-extend
//   mem_rdata    word read data, valid with mem_ack
//   mem_ack      memory read complete
//   mem_rd       memory read request
//   mem_addr     word-aligned memory address
//   result       load result, held until the next accepted start
//   done         one-cycle completion pulse
//   err          error flag (misaligned word or timeout), valid with done
//   busy         high whenever a load is in progress
module byte_load_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic        wb,
  input  logic        sx,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] result,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wb_q, wb_d;
  logic            sx_q, sx_d;
  logic            lane_q, lane_d;
  logic            mem_rd_q, mem_rd_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   result_q, result_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [BW-1:0]   byte_lane;
  logic [DW-1:0]   load_data;

  // Shape the returned word into the final load result.
  always_comb begin
    byte_lane = lane_q ? mem_rdata[15:8] : mem_rdata[7:0];
    if (!wb_q) begin
      load_data = mem_rdata;
    end else if (sx_q) begin
      load_data = {{BW{byte_lane[BW-1]}}, byte_lane};
    end else begin
      load_data = {BW'(0), byte_lane};
    end
  end

  // Next-state and next-output logic; outputs follow the next state so they
  // come straight from flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_d       = wb_q;
    sx_d       = sx_q;
    lane_d     = lane_q;
    mem_addr_d = mem_addr_q;
    result_d   = result_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wb_d       = wb;
          sx_d       = sx;
          lane_d     = addr[0];
          cnt_d      = CW'(0);
          result_d   = DW'(0);
          err_d      = 1'b0;
          mem_addr_d = {addr[AW-1:1], 1'b0};
          // Misaligned word: fail without touching memory.
          if (!wb && addr[0]) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Ack has priority over a timeout in the same cycle.
        if (mem_ack) begin
          result_d = load_data;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          result_d = DW'(0);
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_rd_d = (state_d == S_REQ);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= CW'(0);
      wb_q       <= 1'b0;
      sx_q       <= 1'b0;
      lane_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= AW'(0);
      result_q   <= DW'(0);
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_q       <= wb_d;
      sx_q       <= sx_d;
      lane_q     <= lane_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign result   = result_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_byte_load_unit.sv
// Directed bench for byte_load_unit: a table of single loads plus hand-written
// sequences for ignored inputs, stray acks and reset during a request.
module tb_byte_load_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        wb = 1'b0;
  logic        sx = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] result;
  logic        done;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_err = 0;

  byte_load_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wb(wb), .sx(sx),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .result(result), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        wb;
    logic        sx;
    logic [15:0] rdata;
    int          ack_wait;  // REQ cycles before ack; -1 = never
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_lat;   // cycles from start to done
    int          exp_rd;    // cycles with mem_rd high
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v, input int idx);
    int lat;
    int rd;
    bit got_done;
    logic [15:0] exp_maddr;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_maddr = {v.addr[15:1], 1'b0};
    start = 1'b1; addr = v.addr; wb = v.wb; sx = v.sx;
    step();
    // Scramble inputs to prove they were latched at start.
    start = 1'b0; addr = 16'h5555; wb = ~v.wb; sx = ~v.sx;
    lat = 0; rd = 0; got_done = 1'b0;
    for (int t = 1; t <= 40 && !got_done; t++) begin
      if (mem_rd) begin
        rd++;
        if (rd == 1) chk({tag, " mem_addr"}, mem_addr, exp_maddr);
      end
      if (done) begin
        got_done = 1'b1;
        lat = t;
      end else begin
        if (mem_rd && v.ack_wait >= 0 && rd - 1 == v.ack_wait) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        end
        step();
      end
    end
    mem_ack = 1'b0;
    chk({tag, " done_seen"}, 16'(got_done), 16'd1);
    chk({tag, " latency"}, 16'(lat), 16'(v.exp_lat));
    chk({tag, " rd_cycles"}, 16'(rd), 16'(v.exp_rd));
    chk({tag, " result"}, result, v.exp_res);
    chk({tag, " err"}, 16'(err), 16'(v.exp_err));
    chk({tag, " busy_in_done"}, 16'(busy), 16'd1);
    step();
    chk({tag, " done_pulse"}, 16'(done), 16'd0);
    chk({tag, " busy_after"}, 16'(busy), 16'd0);
    step(); step();
    chk({tag, " result_hold"}, result, v.exp_res);
    chk({tag, " err_hold"}, 16'(err), 16'(v.exp_err));
  endtask

  initial begin
    int n_done;
    int n_rd;
    int n_busy;

    vecs[0] = '{16'h1001, 1'b1, 1'b0, 16'h8A34,  0, 16'h008A, 1'b0, 2, 1};
    vecs[1] = '{16'h2000, 1'b1, 1'b1, 16'h12F0,  3, 16'hFFF0, 1'b0, 5, 4};
    vecs[2] = '{16'h0040, 1'b0, 1'b0, 16'hBEEF,  0, 16'hBEEF, 1'b0, 2, 1};
    vecs[3] = '{16'h0041, 1'b0, 1'b0, 16'h1111,  0, 16'h0000, 1'b1, 1, 0};
    vecs[4] = '{16'h3000, 1'b1, 1'b0, 16'h7777, -1, 16'h0000, 1'b1, 6, 5};
    vecs[5] = '{16'h3002, 1'b0, 1'b0, 16'hCAFE,  4, 16'hCAFE, 1'b0, 6, 5};
    vecs[6] = '{16'h2001, 1'b1, 1'b1, 16'h80FF,  0, 16'hFF80, 1'b0, 2, 1};
    vecs[7] = '{16'h2000, 1'b1, 1'b0, 16'h80FF,  1, 16'h00FF, 1'b0, 3, 2};
    vecs[8] = '{16'h2001, 1'b1, 1'b0, 16'h7F12,  0, 16'h007F, 1'b0, 2, 1};
    vecs[9] = '{16'h2003, 1'b1, 1'b1, 16'h7F92,  2, 16'h007F, 1'b0, 4, 3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_rd", 16'(mem_rd), 16'd0);
    chk("rst mem_addr", mem_addr, 16'h0000);
    chk("rst result", result, 16'h0000);
    chk("rst done", 16'(done), 16'd0);
    chk("rst err", 16'(err), 16'd0);
    chk("rst busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_load(vecs[i], i);

    // Start pulsed during REQ and during DONE must be ignored.
    start = 1'b1; addr = 16'h0100; wb = 1'b0; sx = 1'b0;
    step();
    start = 1'b1; addr = 16'h0301; wb = 1'b0;
    step();
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0;
    chk("ign done", 16'(done), 16'd1);
    chk("ign result", result, 16'h1234);
    chk("ign err", 16'(err), 16'd0);
    start = 1'b1; addr = 16'h0301; wb = 1'b0;
    step();
    start = 1'b0;
    n_done = 0; n_rd = 0; n_busy = 0;
    for (int t = 0; t < 5; t++) begin
      n_done += int'(done); n_rd += int'(mem_rd); n_busy += int'(busy);
      step();
    end
    chk("ign extra_done", 16'(n_done), 16'd0);
    chk("ign extra_rd", 16'(n_rd), 16'd0);
    chk("ign extra_busy", 16'(n_busy), 16'd0);
    chk("ign result_hold", result, 16'h1234);

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    n_done = 0; n_busy = 0;
    for (int t = 0; t < 3; t++) begin
      step();
      n_done += int'(done); n_busy += int'(busy);
    end
    mem_ack = 1'b0;
    chk("stray done", 16'(n_done), 16'd0);
    chk("stray busy", 16'(n_busy), 16'd0);
    chk("stray result", result, 16'h1234);

    // Reset during REQ, then a late ack
    start = 1'b1; addr = 16'h0400; wb = 1'b0;
    step();
    start = 1'b0;
    step();
    chk("mrst rd_before", 16'(mem_rd), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst mem_rd", 16'(mem_rd), 16'd0);
    chk("mrst mem_addr", mem_addr, 16'h0000);
    chk("mrst result", result, 16'h0000);
    chk("mrst done", 16'(done), 16'd0);
    chk("mrst err", 16'(err), 16'd0);
    chk("mrst busy", 16'(busy), 16'd0);
    step();
    #3 rst_n = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    n_done = 0; n_busy = 0; n_rd = 0;
    for (int t = 0; t < 3; t++) begin
      step();
      n_done += int'(done); n_busy += int'(busy); n_rd += int'(mem_rd);
    end
    mem_ack = 1'b0;
    chk("mrst late_done", 16'(n_done), 16'd0);
    chk("mrst late_busy", 16'(n_busy), 16'd0);
    chk("mrst late_rd", 16'(n_rd), 16'd0);
    step();
    run_load(vecs[1], 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
